// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit and its queue.
package fetch_unit_pkg;

  localparam int                  XLEN_DEFAULT = 32;
  localparam int                  INSTR_W      = 32;
  localparam logic [INSTR_W-1:0]  NOP_INSTR    = 32'h0000_0013;  // addi x0,x0,0
  localparam int                  PC_STEP      = 4;

endpackage : fetch_unit_pkg

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries. The head is read
// straight from storage, so a write becomes visible one cycle later (no bypass).
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign do_wr     = wr_en_i && !full;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; pointers wrap naturally at 2^AW.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; emptiness is tracked by count_q alone.
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetches under a credit limit,
// tracks in-flight requests, discards stale responses after a redirect and
// buffers good instructions in fetch_queue for the decode stage.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000),
  parameter int              FQ_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [INSTR_W-1:0]         imem_rsp_data,
  output logic                       if_valid,
  input  logic                       if_ready,
  output logic [INSTR_W-1:0]         if_instr,
  output logic [XLEN-1:0]            if_pc,
  output logic [$clog2(FQ_DEPTH):0]  fq_count
);

  localparam int              CW             = $clog2(FQ_DEPTH) + 1;
  localparam int              QW             = XLEN + INSTR_W;
  localparam logic [XLEN-1:0] RESET_PC_ALIGN = {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;   // address of the next request
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;       // pc of the next kept response
  logic [CW-1:0]   inflight_q, inflight_d;   // accepted requests awaiting response
  logic [CW-1:0]   discard_q, discard_d;     // stale responses still to drop

  logic [XLEN-1:0] redirect_target;
  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            if_fire;
  logic            rsp_keep;
  logic            q_empty;
  logic [QW-1:0]   q_head;

  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign credit_used     = {1'b0, fq_count} + {1'b0, inflight_q};

  // A request is only offered when the queue is guaranteed room for its
  // response, and never in the redirect cycle or while reset is held.
  assign imem_req_valid  = !rst && !redirect_valid &&
                           (credit_used < (CW+1)'(FQ_DEPTH));
  assign imem_req_addr   = {fetch_pc_q[XLEN-1:2], 2'b00};
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign if_fire         = if_valid && if_ready;
  assign rsp_keep        = imem_rsp_valid && !redirect_valid && (discard_q == '0);

  assign if_valid = !q_empty;
  assign if_instr = q_empty ? NOP_INSTR : q_head[INSTR_W-1:0];
  assign if_pc    = q_empty ? '0        : q_head[QW-1:INSTR_W];

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (redirect_valid),
    .wr_en_i   (rsp_keep),
    .wr_data_i ({rsp_pc_q, imem_rsp_data}),
    .rd_en_i   (if_fire),
    .rd_data_o (q_head),
    .empty_o   (q_empty),
    .count_o   (fq_count)
  );

  // Next-state for fetch pc, response pc, in-flight and discard counters.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;

    if (req_fire)       inflight_d = inflight_d + 1'b1;
    if (imem_rsp_valid) inflight_d = inflight_d - 1'b1;

    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
      // No request fires in this cycle and any response here is dropped, so
      // everything still outstanding afterwards is stale.
      discard_d  = inflight_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      if (rsp_keep) rsp_pc_d   = rsp_pc_q + XLEN'(PC_STEP);
      if (imem_rsp_valid && discard_q != '0) discard_d = discard_q - 1'b1;
    end
  end

  // Fetch-side state registers; reset abandons all outstanding requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC_ALIGN;
      rsp_pc_q   <= RESET_PC_ALIGN;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

endmodule : fetch_unit
